// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//
// Boot-time program loader. Receives a program image over a byte stream
// (typically a UART receiver) and writes it into the core's instruction
// memory. The stream is one count byte N (number of 32-bit words, 1..DEPTH)
// followed by 4*N data bytes, little-endian within each word. Words not
// covered by the image are filled with NOOP, and the last word of memory
// with a branch-to-self, so a short program can never run off into stale
// memory. The core is held while loading and released on success.
//
// Ports
//   clk         in   system clock, all state on the rising edge
//   rst         in   asynchronous active-high reset
//   start       in   single-cycle request to (re)load a program
//   rx_valid    in   one-cycle strobe, rx_data holds a received byte
//   rx_data     in   received byte
//   imem_we     out  instruction-memory write enable
//   imem_addr   out  word-aligned byte address of the write
//   imem_wdata  out  instruction word to write
//   core_hold   out  1 holds the core in reset/stall (everything but RUN)
//   load_done   out  one-cycle pulse on entry to RUN
//   load_error  out  sticky error flag, cleared by start or rst
//
// All outputs are registered. They are computed from the next state, so
// each output register lines up with the state register it belongs to.
// -----------------------------------------------------------------------------
module prog_loader #(
  parameter int unsigned ADDR_WIDTH       = 8,
  parameter int unsigned BAUD_COUNT_CHECK = 16,
  parameter int unsigned TIMEOUT_CYCLES   = 20 * BAUD_COUNT_CHECK
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_hold,
  output logic                  load_done,
  output logic                  load_error
);

  localparam int unsigned DEPTH  = 32'd1 << (ADDR_WIDTH - 2);
  // One bit wider than a word address so it can hold the count DEPTH.
  localparam int unsigned WIDX_W = ADDR_WIDTH - 1;
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]     NOOP     = 32'h0000_0013;
  localparam logic [31:0]     INF_LOOP = 32'h0000_0063;

  typedef enum logic [2:0] {
    LOAD_COUNT = 3'd0,
    LOAD_DATA  = 3'd1,
    WRITE      = 3'd2,
    FILL       = 3'd3,
    RUN        = 3'd4,
    ERROR      = 3'd5
  } state_t;

  state_t              state_q,    state_d;
  logic [7:0]          n_q,        n_d;
  logic [WIDX_W-1:0]   word_idx_q, word_idx_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [31:0]         word_q,     word_d;
  logic [TO_W-1:0]     to_cnt_q,   to_cnt_d;

  logic                  imem_we_q,    imem_we_d;
  logic [ADDR_WIDTH-1:0] imem_addr_q,  imem_addr_d;
  logic [31:0]           imem_wdata_q, imem_wdata_d;
  logic                  core_hold_q,  core_hold_d;
  logic                  load_done_q,  load_done_d;
  logic                  load_error_q, load_error_d;

  logic count_ok_s;
  logic more_words_s;
  logic full_image_s;
  logic last_word_s;

  // Insert a received byte into the word under assembly (little-endian).
  function automatic logic [31:0] put_byte(input logic [31:0] w,
                                           input logic [1:0]  idx,
                                           input logic [7:0]  b);
    logic [31:0] r;
    r = w;
    case (idx)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      2'd3:    r[31:24] = b;
      default: r        = w;
    endcase
    return r;
  endfunction

  // Decode helpers for count validation and post-write routing.
  always_comb begin
    count_ok_s   = (rx_data != 8'd0) && (32'(rx_data) <= DEPTH);
    more_words_s = (32'(word_idx_q) + 32'd1) < 32'(n_q);
    full_image_s = (32'(n_q) == DEPTH);
    last_word_s  = (32'(word_idx_q) == (DEPTH - 32'd1));
  end

  // Next-state and datapath logic of the loader FSM.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    to_cnt_d   = to_cnt_q;

    if (start) begin
      // start overrides everything, including a coincident rx_valid byte.
      state_d    = LOAD_COUNT;
      n_d        = 8'd0;
      word_idx_d = '0;
      byte_idx_d = 2'd0;
      word_d     = 32'd0;
      to_cnt_d   = '0;
    end else begin
      case (state_q)
        LOAD_COUNT: begin
          if (rx_valid) begin
            n_d = rx_data;
            if (count_ok_s) begin
              state_d    = LOAD_DATA;
              word_idx_d = '0;
              byte_idx_d = 2'd0;
              to_cnt_d   = '0;
            end else begin
              state_d = ERROR;
            end
          end else begin
            state_d = LOAD_COUNT;
          end
        end

        LOAD_DATA: begin
          if (rx_valid) begin
            word_d   = put_byte(word_q, byte_idx_q, rx_data);
            to_cnt_d = '0;
            if (byte_idx_q == 2'd3) begin
              state_d    = WRITE;
              byte_idx_d = 2'd0;
            end else begin
              byte_idx_d = byte_idx_q + 2'd1;
            end
          end else if (to_cnt_q == TO_LAST) begin
            // Stream stalled; words already written are left as they are.
            state_d = ERROR;
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end

        WRITE: begin
          word_idx_d = word_idx_q + WIDX_W'(1);
          if (more_words_s) begin
            state_d  = LOAD_DATA;
            to_cnt_d = '0;
            // The sender may stream without gaps: a byte arriving while the
            // previous word is being written starts the next word.
            if (rx_valid) begin
              word_d     = put_byte(word_q, 2'd0, rx_data);
              byte_idx_d = 2'd1;
            end else begin
              byte_idx_d = 2'd0;
            end
          end else if (full_image_s) begin
            state_d = RUN;
          end else begin
            state_d = FILL;
          end
        end

        FILL: begin
          // word_idx_q is the word being written in this cycle.
          if (last_word_s) begin
            state_d = RUN;
          end else begin
            word_idx_d = word_idx_q + WIDX_W'(1);
          end
        end

        RUN: begin
          state_d = RUN;
        end

        ERROR: begin
          state_d = ERROR;
        end

        default: begin
          state_d = ERROR;
        end
      endcase
    end
  end

  // Output decode from the next state so the output registers track state_q.
  always_comb begin
    imem_we_d    = (state_d == WRITE) || (state_d == FILL);
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    core_hold_d  = (state_d != RUN);
    load_done_d  = (state_d == RUN) && (state_q != RUN);
    load_error_d = (state_d == ERROR);

    if (state_d == WRITE) begin
      imem_addr_d  = {word_idx_d[ADDR_WIDTH-3:0], 2'b00};
      imem_wdata_d = word_d;
    end else if (state_d == FILL) begin
      imem_addr_d  = {word_idx_d[ADDR_WIDTH-3:0], 2'b00};
      imem_wdata_d = (32'(word_idx_d) == (DEPTH - 32'd1)) ? INF_LOOP : NOOP;
    end else begin
      imem_addr_d  = imem_addr_q;
      imem_wdata_d = imem_wdata_q;
    end
  end

  // FSM state and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= LOAD_COUNT;
      n_q        <= 8'd0;
      word_idx_q <= '0;
      byte_idx_q <= 2'd0;
      word_q     <= 32'd0;
      to_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= 32'd0;
      core_hold_q  <= 1'b1;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      core_hold_q  <= core_hold_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign core_hold  = core_hold_q;
  assign load_done  = load_done_q;
  assign load_error = load_error_q;

endmodule

// File: tb/tb_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_loader
//
// Directed bench for prog_loader (ADDR_WIDTH 8 -> 64 words, short timeout).
// A negedge monitor records every instruction-memory write; each test task
// drives a byte stream and compares outputs and recorded writes against
// hand-computed values.
// -----------------------------------------------------------------------------
module tb_prog_loader;

  localparam int AW = 8;
  localparam int TO = 40;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_hold;
  logic          load_done;
  logic          load_error;

  int checks   = 0;
  int failures = 0;

  logic [AW-1:0] wa[$];
  logic [31:0]   wd[$];

  always #5 clk = ~clk;

  prog_loader #(
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_hold  (core_hold),
    .load_done  (load_done),
    .load_error (load_error)
  );

  // Record every memory write, sampled away from the active edge.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (load_done !== 1'b1 && n < 500) begin
      tick();
      n++;
    end
  endtask

  function automatic logic [31:0] full_word(input int w);
    logic [7:0] b;
    b = 8'(w);
    return {8'(255 - w), 8'hC3, b ^ 8'hA5, b};
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    tick(); tick();
    checks++; if (imem_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", imem_we); end
    checks++; if (imem_addr !== 8'h00) begin failures++; $display("FAIL reset_addr got=%h exp=00", imem_addr); end
    checks++; if (imem_wdata !== 32'h0) begin failures++; $display("FAIL reset_wdata got=%h exp=0", imem_wdata); end
    checks++; if (core_hold !== 1'b1) begin failures++; $display("FAIL reset_hold got=%b exp=1", core_hold); end
    checks++; if (load_done !== 1'b0 || load_error !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", load_done, load_error); end
    rst = 1'b0;
    tick();
    checks++; if (core_hold !== 1'b1 || imem_we !== 1'b0) begin failures++; $display("FAIL post_reset got hold=%b we=%b exp hold=1 we=0", core_hold, imem_we); end
  endtask

  task automatic test_single_word();
    int n; int bad; logic prev_hold;
    wa.delete(); wd.delete();
    send(8'h01); send(8'h93); send(8'h00); send(8'h10); send(8'h00);
    checks++; if (imem_we !== 1'b1 || imem_addr !== 8'h00 || imem_wdata !== 32'h00100093) begin
      failures++; $display("FAIL single_write got we=%b a=%h d=%h exp we=1 a=00 d=00100093", imem_we, imem_addr, imem_wdata); end
    n = 0; prev_hold = core_hold;
    while (load_done !== 1'b1 && n < 500) begin prev_hold = core_hold; tick(); n++; end
    checks++; if (load_done !== 1'b1) begin failures++; $display("FAIL single_done got=%b exp=1 (timeout)", load_done); end
    checks++; if (prev_hold !== 1'b1 || core_hold !== 1'b0) begin failures++; $display("FAIL single_hold_edge got=%b->%b exp=1->0", prev_hold, core_hold); end
    checks++; if (wa.size() != 64) begin failures++; $display("FAIL single_nwrites got=%0d exp=64", wa.size()); end
    checks++; if (wa[0] !== 8'h00 || wd[0] !== 32'h00100093) begin failures++; $display("FAIL single_w0 got a=%h d=%h exp a=00 d=00100093", wa[0], wd[0]); end
    bad = 0;
    for (int i = 1; i < 63 && i < wa.size(); i++) begin
      if (wa[i] !== 8'(i * 4) || wd[i] !== 32'h00000013) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL fill_noop got bad=%0d exp=0", bad); end
    checks++; if (wa[63] !== 8'hFC || wd[63] !== 32'h00000063) begin failures++; $display("FAIL fill_last got a=%h d=%h exp a=fc d=00000063", wa[63], wd[63]); end
    tick();
    checks++; if (load_done !== 1'b0 || core_hold !== 1'b0) begin failures++; $display("FAIL single_run got done=%b hold=%b exp done=0 hold=0", load_done, core_hold); end
  endtask

  task automatic test_full();
    logic [31:0] w; int bad;
    pulse_start();
    checks++; if (core_hold !== 1'b1 || load_done !== 1'b0 || load_error !== 1'b0) begin
      failures++; $display("FAIL full_start got hold=%b done=%b err=%b exp 1 0 0", core_hold, load_done, load_error); end
    wa.delete(); wd.delete();
    send(8'h40);
    for (int i = 0; i < 64; i++) begin
      w = full_word(i);
      send(w[7:0]); send(w[15:8]); send(w[23:16]); send(w[31:24]);
    end
    checks++; if (imem_we !== 1'b1 || imem_addr !== 8'hFC) begin failures++; $display("FAIL full_last got we=%b a=%h exp we=1 a=fc", imem_we, imem_addr); end
    tick();
    checks++; if (load_done !== 1'b1 || imem_we !== 1'b0 || core_hold !== 1'b0) begin
      failures++; $display("FAIL full_run got done=%b we=%b hold=%b exp 1 0 0", load_done, imem_we, core_hold); end
    checks++; if (wa.size() != 64) begin failures++; $display("FAIL full_nwrites got=%0d exp=64", wa.size()); end
    bad = 0;
    for (int i = 0; i < wa.size(); i++) begin
      if (wa[i] !== 8'(i * 4) || wd[i] !== full_word(i)) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL full_data got bad=%0d exp=0", bad); end
  endtask

  task automatic test_bad_count();
    int n0;
    pulse_start();
    n0 = wa.size();
    send(8'h00);
    checks++; if (load_error !== 1'b1 || core_hold !== 1'b1) begin failures++; $display("FAIL cnt0_err got err=%b hold=%b exp 1 1", load_error, core_hold); end
    send(8'h01); send(8'h93); send(8'h00); send(8'h10); send(8'h00);
    checks++; if (load_error !== 1'b1 || wa.size() != n0) begin failures++; $display("FAIL cnt0_sticky got err=%b writes=%0d exp err=1 writes=%0d", load_error, wa.size(), n0); end
    pulse_start();
    checks++; if (load_error !== 1'b0 || core_hold !== 1'b1) begin failures++; $display("FAIL err_clear got err=%b hold=%b exp 0 1", load_error, core_hold); end
    send(8'h41);
    checks++; if (load_error !== 1'b1 || imem_we !== 1'b0) begin failures++; $display("FAIL cnt41_err got err=%b we=%b exp 1 0", load_error, imem_we); end
    tick();
    checks++; if (wa.size() != n0) begin failures++; $display("FAIL bad_nowrite got=%0d exp=%0d", wa.size(), n0); end
    pulse_start();
    checks++; if (load_error !== 1'b0) begin failures++; $display("FAIL err_clear2 got=%b exp=0", load_error); end
  endtask

  task automatic test_timeout();
    int n;
    wa.delete(); wd.delete();
    send(8'h02); send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55);
    n = 0;
    while (load_error !== 1'b1 && n < 500) begin tick(); n++; end
    checks++; if (n != TO) begin failures++; $display("FAIL timeout_cycles got=%0d exp=%0d", n, TO); end
    checks++; if (wa.size() != 1 || wa[0] !== 8'h00 || wd[0] !== 32'h44332211) begin
      failures++; $display("FAIL timeout_writes got n=%0d a=%h d=%h exp n=1 a=00 d=44332211", wa.size(), wa[0], wd[0]); end
    send(8'hAA); send(8'hAA); send(8'hAA); send(8'hAA);
    checks++; if (wa.size() != 1 || core_hold !== 1'b1 || load_error !== 1'b1) begin
      failures++; $display("FAIL timeout_after got n=%0d hold=%b err=%b exp 1 1 1", wa.size(), core_hold, load_error); end
  endtask

  task automatic test_start_mid_word();
    int n;
    pulse_start();
    wa.delete(); wd.delete();
    send(8'h01); send(8'hAA); send(8'hBB);
    start = 1'b1; rx_valid = 1'b1; rx_data = 8'hCC;
    tick();
    start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    checks++; if (imem_we !== 1'b0 || core_hold !== 1'b1 || load_error !== 1'b0) begin
      failures++; $display("FAIL start_rx got we=%b hold=%b err=%b exp 0 1 0", imem_we, core_hold, load_error); end
    for (int i = 0; i < TO + 5; i++) tick();
    checks++; if (load_error !== 1'b0) begin failures++; $display("FAIL count_no_timeout got=%b exp=0", load_error); end
    send(8'h01); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    checks++; if (imem_we !== 1'b1 || imem_addr !== 8'h00 || imem_wdata !== 32'h04030201) begin
      failures++; $display("FAIL restart_write got we=%b a=%h d=%h exp we=1 a=00 d=04030201", imem_we, imem_addr, imem_wdata); end
    wait_done(n);
    checks++; if (load_done !== 1'b1 || wa.size() != 64) begin failures++; $display("FAIL restart_done got done=%b n=%0d exp 1 64", load_done, wa.size()); end
  endtask

  task automatic test_rst_fill();
    int n0; int n;
    pulse_start();
    send(8'h01); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    tick(); tick(); tick();
    checks++; if (imem_we !== 1'b1 || imem_wdata !== 32'h00000013) begin failures++; $display("FAIL in_fill got we=%b d=%h exp we=1 d=00000013", imem_we, imem_wdata); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (imem_we !== 1'b0 || imem_addr !== 8'h00 || imem_wdata !== 32'h0) begin
      failures++; $display("FAIL rst_fill_out got we=%b a=%h d=%h exp 0 00 0", imem_we, imem_addr, imem_wdata); end
    checks++; if (core_hold !== 1'b1 || load_done !== 1'b0 || load_error !== 1'b0) begin
      failures++; $display("FAIL rst_fill_flags got hold=%b done=%b err=%b exp 1 0 0", core_hold, load_done, load_error); end
    n0 = wa.size();
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    checks++; if (wa.size() != n0 || imem_we !== 1'b0) begin failures++; $display("FAIL rst_nowrite got n=%0d we=%b exp n=%0d we=0", wa.size(), imem_we, n0); end
    wa.delete(); wd.delete();
    send(8'h01); send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
    checks++; if (imem_we !== 1'b1 || imem_addr !== 8'h00 || imem_wdata !== 32'hEFBEADDE) begin
      failures++; $display("FAIL rst_reload got we=%b a=%h d=%h exp we=1 a=00 d=efbeadde", imem_we, imem_addr, imem_wdata); end
    wait_done(n);
    checks++; if (load_done !== 1'b1) begin failures++; $display("FAIL rst_reload_done got=%b exp=1 after %0d cycles", load_done, n); end
  endtask

  task automatic test_back_to_back();
    int n;
    pulse_start();
    wa.delete(); wd.delete();
    send(8'h02); send(8'h10); send(8'h20); send(8'h30); send(8'h40);
    checks++; if (imem_we !== 1'b1 || imem_addr !== 8'h00 || imem_wdata !== 32'h40302010) begin
      failures++; $display("FAIL b2b_w0 got we=%b a=%h d=%h exp we=1 a=00 d=40302010", imem_we, imem_addr, imem_wdata); end
    send(8'h50); send(8'h60); send(8'h70); send(8'h80);
    checks++; if (imem_we !== 1'b1 || imem_addr !== 8'h04 || imem_wdata !== 32'h80706050) begin
      failures++; $display("FAIL b2b_w1 got we=%b a=%h d=%h exp we=1 a=04 d=80706050", imem_we, imem_addr, imem_wdata); end
    wait_done(n);
    checks++; if (load_done !== 1'b1 || wa.size() != 64 || wd[1] !== 32'h80706050) begin
      failures++; $display("FAIL b2b_done got done=%b n=%0d d1=%h exp 1 64 80706050", load_done, wa.size(), wd[1]); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_full();
    test_bad_count();
    test_timeout();
    test_start_mid_word();
    test_rst_fill();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8 (PROGRAM_ADDRESS_WIDTH), byte-address width of instruction memory; depth DEPTH = 2^(ADDR_WIDTH-2) words (64 at default).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 20*BAUD_COUNT_CHECK, max idle cycles between bytes of a word stream.
REQ-003 SHALL have port clk  input  1  system clock; one clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  single-cycle request to (re)load program.
REQ-006 SHALL have port rx_valid  input  1  one-cycle strobe, UART receiver byte ready.
REQ-007 SHALL have port rx_data  input  8  received byte, valid with rx_valid.
REQ-008 SHALL have port imem_we  output  1  instruction-memory write enable.
REQ-009 SHALL have port imem_addr  output  ADDR_WIDTH  word-aligned byte address, bits [1:0] always 0.
REQ-010 SHALL have port imem_wdata  output  32  instruction word.
REQ-011 SHALL have port core_hold  output  1  holds pipeline in reset/stall while 1.
REQ-012 SHALL have port load_done  output  1  one-cycle pulse on successful load.
REQ-013 SHALL have port load_error  output  1  sticky error flag.

Function
REQ-014 SHALL implement states LOAD_COUNT, LOAD_DATA, WRITE, FILL, RUN, ERROR; all outputs registered.
REQ-015 LOAD_COUNT: on rx_valid, N = rx_data; N in 1..DEPTH -> word index 0, byte index 0, LOAD_DATA; else -> ERROR; no timeout in this state.
REQ-016 LOAD_DATA: each rx_valid stores byte at byte index (little-endian: byte 0 -> bits [7:0]); after byte 3 -> WRITE next cycle.
REQ-017 WRITE: imem_we=1 exactly one cycle, imem_addr = word index*4, imem_wdata = assembled word; word index increments.
REQ-018 After WRITE: word index < N -> LOAD_DATA; N == DEPTH -> RUN; else -> FILL.
REQ-019 rx_valid in WRITE cycle SHALL be accepted as byte 0 of next word (no byte lost).
REQ-020 FILL: one write per cycle at words N..DEPTH-2 with NOOP (0x00000013), then word DEPTH-1 with INF_LOOP (0x00000063), then RUN; rx_valid ignored.
REQ-021 Timeout counter clears on every accepted byte and on LOAD_DATA entry; reaching TIMEOUT_CYCLES in LOAD_DATA -> ERROR; already-written words untouched.
REQ-022 RUN: core_hold=0; load_done=1 for exactly the first RUN cycle; rx_valid ignored.
REQ-023 ERROR: load_error=1, core_hold=1, imem_we=0; rx_valid ignored.
REQ-024 start in any state -> LOAD_COUNT next cycle, core_hold=1, load_error cleared, in-progress word discarded, no write that cycle.
REQ-025 start coincident with rx_valid: start wins, byte discarded.
REQ-026 core_hold SHALL be 1 in every state except RUN; imem_we 1 only in WRITE and FILL.

Reset
REQ-027 rst asserted SHALL immediately force LOAD_COUNT, imem_we=0, imem_addr=0, imem_wdata=0, core_hold=1, load_done=0, load_error=0, counters 0.
REQ-028 rst mid-WRITE/FILL SHALL abort with no further writes; loading restarts from a new count byte.

Verification
REQ-029 Bytes 0x01,0x93,0x00,0x10,0x00 -> one write addr 0x00 data 0x00100093; FILL writes 0x13 at 0x04..0xF8 (62 writes), 0x63 at 0xFC; then load_done pulse, core_hold 1->0 same cycle.
REQ-030 Count 0x40 plus 256 bytes -> 64 writes 0x00..0xFC, no FILL, RUN right after write at 0xFC.
REQ-031 Count 0x00 or 0x41 -> load_error=1, no imem_we, core_hold=1; then start -> load_error=0, LOAD_COUNT.
REQ-032 Count 0x02, 5 data bytes, silence -> one write at 0x00, load_error after TIMEOUT_CYCLES idle cycles.
REQ-033 start coincident with rx_valid mid-word -> byte dropped, no write, new count byte accepted; rst during FILL -> imem_we=0 immediately, all outputs at reset values.
REQ-034 Back-to-back rx_valid on WRITE cycle of word 0 -> byte lands in word 1 bits [7:0].
